// File: rtl/instruction_input_arbiter_if.sv
// Handshake bundle between the per-channel instruction producers, the arbiter and the decoder.
// master = producer/consumer side (testbench or fetch/decoder), slave = arbiter side.
interface instruction_input_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4
);
  logic [CHANNELS*ADDR_WIDTH-1:0] in_move_from;
  logic [CHANNELS-1:0]            in_move_valid;
  logic [CHANNELS-1:0]            in_move_ack;
  logic [CHANNELS*DATA_WIDTH-1:0] in_immediate;
  logic [CHANNELS-1:0]            in_immediate_valid;
  logic [CHANNELS-1:0]            in_immediate_ack;
  logic                           out_kind;
  logic [$clog2(CHANNELS)-1:0]    out_channel;
  logic [ADDR_WIDTH-1:0]          out_move_from;
  logic [DATA_WIDTH-1:0]          out_immediate;
  logic                           out_valid;
  logic                           out_ack;

  modport master (
    output in_move_from, in_move_valid, in_immediate, in_immediate_valid, out_ack,
    input  in_move_ack, in_immediate_ack, out_kind, out_channel, out_move_from,
           out_immediate, out_valid
  );

  modport slave (
    input  in_move_from, in_move_valid, in_immediate, in_immediate_valid, out_ack,
    output in_move_ack, in_immediate_ack, out_kind, out_channel, out_move_from,
           out_immediate, out_valid
  );
endinterface

// File: rtl/instruction_input_arbiter.sv
// Round-robin arbiter of move/immediate words from CHANNELS producers into one tagged FIFO stream.
// Latency 1 cycle into an empty FIFO; acks are combinational and drop while the FIFO is full.
// Optional per-channel accept counters when INSTR_ARB_STATS_EN is defined.
module instruction_input_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int DEPTH      = 4
) (
  input logic clk,
  input logic resetn,
  instruction_input_arbiter_if.slave bus
`ifdef INSTR_ARB_STATS_EN
  ,
  output logic [CHANNELS*16-1:0] stat_accepted
`endif
);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic                  kind;
    logic [CH_W-1:0]       channel;
    logic [ADDR_WIDTH-1:0] move_from;
    logic [DATA_WIDTH-1:0] immediate;
  } entry_t;

  logic [CH_W-1:0]       rr;
  logic [CH_W-1:0]       gnt_ch;
  logic                  gnt_vld;
  logic                  gnt_move;
  logic [CHANNELS-1:0]   req;
  logic [CHANNELS-1:0]   move_ack;
  logic [CHANNELS-1:0]   imm_ack;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  out_valid_i;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  entry_t                mem [DEPTH];
  entry_t                push_ent;
  entry_t                head;
  logic [ADDR_WIDTH-1:0] mv_arr [CHANNELS];
  logic [DATA_WIDTH-1:0] im_arr [CHANNELS];
  int                    search_idx;

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      mv_arr[c] = bus.in_move_from[c*ADDR_WIDTH +: ADDR_WIDTH];
      im_arr[c] = bus.in_immediate[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req         = bus.in_move_valid | bus.in_immediate_valid;
  assign full        = (count == (PTR_W+1)'(DEPTH));
  assign out_valid_i = (count != '0);
  assign pop         = out_valid_i && bus.out_ack;

  // First requester at or after rr, wrapping.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_ch     = '0;
    search_idx = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!gnt_vld) begin
        search_idx = int'(rr) + i;
        if (search_idx >= CHANNELS) search_idx = search_idx - CHANNELS;
        if (req[CH_W'(search_idx)]) begin
          gnt_vld = 1'b1;
          gnt_ch  = CH_W'(search_idx);
        end
      end
    end
  end

  // Reset gates the acks so a word presented during reset is never taken.
  assign gnt_move = bus.in_move_valid[gnt_ch];
  assign push     = resetn && gnt_vld && !full;

  always_comb begin
    move_ack = '0;
    imm_ack  = '0;
    if (push) begin
      if (gnt_move) move_ack[gnt_ch] = 1'b1;
      else          imm_ack[gnt_ch]  = 1'b1;
    end
  end

  assign bus.in_move_ack      = move_ack;
  assign bus.in_immediate_ack = imm_ack;

  always_comb begin
    push_ent.kind      = !gnt_move;
    push_ent.channel   = gnt_ch;
    push_ent.move_from = gnt_move ? mv_arr[gnt_ch] : '0;
    push_ent.immediate = gnt_move ? '0 : im_arr[gnt_ch];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        rr          <= (gnt_ch == CH_W'(CHANNELS-1)) ? '0 : gnt_ch + CH_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head              = mem[rd_ptr];
  assign bus.out_kind      = head.kind;
  assign bus.out_channel   = head.channel;
  assign bus.out_move_from = head.move_from;
  assign bus.out_immediate = head.immediate;
  assign bus.out_valid     = out_valid_i;

`ifdef INSTR_ARB_STATS_EN
  logic [15:0] stat_cnt [CHANNELS];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int c = 0; c < CHANNELS; c++) stat_cnt[c] <= '0;
    end else if (push && stat_cnt[gnt_ch] != 16'hFFFF) begin
      stat_cnt[gnt_ch] <= stat_cnt[gnt_ch] + 16'd1;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) stat_accepted[c*16 +: 16] = stat_cnt[c];
  end
`endif
endmodule

// File: tb/tb_instruction_input_arbiter.sv
// Directed bench for instruction_input_arbiter; scoreboard queue checked by a separate output monitor.
module tb_instruction_input_arbiter;
  logic clk;
  logic resetn;

  instruction_input_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CHANNELS(4)) bus ();

`ifdef INSTR_ARB_STATS_EN
  logic [63:0] stat_accepted;
`endif

  instruction_input_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .CHANNELS(4), .DEPTH(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef INSTR_ARB_STATS_EN
    ,
    .stat_accepted (stat_accepted)
`endif
  );

  typedef struct packed {
    logic        kind;
    logic [1:0]  ch;
    logic [7:0]  mf;
    logic [31:0] imm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(logic k, logic [1:0] ch, logic [7:0] mf, logic [31:0] imm);
    exp_t e;
    e.kind = k;
    e.ch   = ch;
    e.mf   = mf;
    e.imm  = imm;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: every accepted head must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && bus.out_valid && bus.out_ack) begin
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mon_kind", 64'(bus.out_kind), 64'(e.kind));
          chk("mon_channel", 64'(bus.out_channel), 64'(e.ch));
          chk("mon_move_from", 64'(bus.out_move_from), 64'(e.mf));
          chk("mon_immediate", 64'(bus.out_immediate), 64'(e.imm));
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_seq [8];
    logic [1:0] full_seq [4];
    logic [1:0] resume_seq [3];
    rr_seq     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    full_seq   = '{2'd2, 2'd3, 2'd0, 2'd1};
    resume_seq = '{2'd2, 2'd3, 2'd0};

    // Reset held 3 cycles with every valid high: nothing accepted, outputs zero.
    resetn                 = 1'b0;
    bus.in_move_from       = 32'hA3A2A1A0;
    bus.in_immediate       = {4{32'h12345678}};
    bus.in_move_valid      = 4'hF;
    bus.in_immediate_valid = 4'hF;
    bus.out_ack            = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_move_ack", 64'(bus.in_move_ack), 64'h0);
      chk("rst_imm_ack", 64'(bus.in_immediate_ack), 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    end
    chk("rst_out_kind", 64'(bus.out_kind), 64'h0);
    chk("rst_out_channel", 64'(bus.out_channel), 64'h0);
    chk("rst_out_move_from", 64'(bus.out_move_from), 64'h0);
    chk("rst_out_immediate", 64'(bus.out_immediate), 64'h0);
    step();
    resetn                 = 1'b1;
    bus.in_move_valid      = 4'h0;
    bus.in_immediate_valid = 4'h0;

    // Single move on channel 2, visible next cycle.
    step();
    bus.in_move_from  = 32'h005A0000;
    bus.in_move_valid = 4'b0100;
    @(negedge clk);
    chk("single_move_ack", 64'(bus.in_move_ack), 64'h4);
    chk("single_imm_ack", 64'(bus.in_immediate_ack), 64'h0);
    exp_q.push_back(mk(1'b0, 2'd2, 8'h5A, 32'h0));
    step();
    bus.in_move_valid = 4'b0000;
    @(negedge clk);
    chk("single_out_valid", 64'(bus.out_valid), 64'h1);
    chk("single_out_kind", 64'(bus.out_kind), 64'h0);
    chk("single_out_channel", 64'(bus.out_channel), 64'h2);
    chk("single_out_move_from", 64'(bus.out_move_from), 64'h5A);
    step();
    bus.out_ack = 1'b1;
    step();
    bus.out_ack = 1'b0;
    @(negedge clk);
    chk("single_drained", 64'(bus.out_valid), 64'h0);

    // Reset pulse returns rr to 0, then all channels contend.
    step();
    resetn = 1'b0;
    step();
    resetn            = 1'b1;
    bus.in_move_from  = 32'h13121110;
    bus.in_move_valid = 4'hF;
    bus.out_ack       = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_move_ack", 64'(bus.in_move_ack), 64'(4'b0001 << rr_seq[i]));
      exp_q.push_back(mk(1'b0, rr_seq[i], 8'h10 + 8'(rr_seq[i]), 32'h0));
      step();
    end
    bus.in_move_valid = 4'h0;
    repeat (3) step();

    // Channel 1 offers move and immediate together; move wins first.
    bus.in_move_from       = 32'h00001100;
    bus.in_immediate       = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
    bus.in_move_valid      = 4'b0010;
    bus.in_immediate_valid = 4'b0010;
    @(negedge clk);
    chk("prio_move_ack", 64'(bus.in_move_ack), 64'h2);
    chk("prio_imm_ack_blocked", 64'(bus.in_immediate_ack), 64'h0);
    exp_q.push_back(mk(1'b0, 2'd1, 8'h11, 32'h0));
    step();
    bus.in_move_valid = 4'b0000;
    @(negedge clk);
    chk("prio_imm_ack", 64'(bus.in_immediate_ack), 64'h2);
    chk("prio_move_ack_idle", 64'(bus.in_move_ack), 64'h0);
    exp_q.push_back(mk(1'b1, 2'd1, 8'h00, 32'hDEADBEEF));
    step();
    bus.in_immediate_valid = 4'b0000;
    repeat (3) step();

    // Backpressure: four acks fill the FIFO, then none until the consumer pops.
    bus.out_ack       = 1'b0;
    bus.in_move_from  = 32'h23222120;
    bus.in_move_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        chk("fill_move_ack", 64'(bus.in_move_ack), 64'(4'b0001 << full_seq[i]));
        exp_q.push_back(mk(1'b0, full_seq[i], 8'h20 + 8'(full_seq[i]), 32'h0));
      end else begin
        chk("full_move_ack", 64'(bus.in_move_ack), 64'h0);
      end
      step();
    end
    bus.out_ack = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle_ack", 64'(bus.in_move_ack), 64'h0);
    chk("full_pop_cycle_valid", 64'(bus.out_valid), 64'h1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("resume_move_ack", 64'(bus.in_move_ack), 64'(4'b0001 << resume_seq[i]));
      exp_q.push_back(mk(1'b0, resume_seq[i], 8'h20 + 8'(resume_seq[i]), 32'h0));
      step();
    end
    bus.in_move_valid = 4'h0;
    repeat (6) step();
    @(negedge clk);
    chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'h0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'h0);

    // Reset while a word sits in the FIFO and another is being offered.
    step();
    bus.out_ack            = 1'b0;
    bus.in_immediate       = {32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
    bus.in_immediate_valid = 4'b1000;
    @(negedge clk);
    chk("midrst_first_ack", 64'(bus.in_immediate_ack), 64'h8);
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("midrst_ack_blocked", 64'(bus.in_immediate_ack), 64'h0);
    step();
    @(negedge clk);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_out_immediate", 64'(bus.out_immediate), 64'h0);
    chk("midrst_out_kind", 64'(bus.out_kind), 64'h0);
    step();
    resetn                 = 1'b1;
    bus.in_immediate_valid = 4'h0;
    step();

`ifdef INSTR_ARB_STATS_EN
    // Saturation of the channel-0 counter.
    bus.in_move_from  = 32'h000000C0;
    bus.in_move_valid = 4'b0001;
    bus.out_ack       = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      exp_q.push_back(mk(1'b0, 2'd0, 8'hC0, 32'h0));
      step();
    end
    bus.in_move_valid = 4'h0;
    repeat (3) step();
    @(negedge clk);
    chk("stat_ch0_saturated", 64'(stat_accepted[15:0]), 64'hFFFF);
    chk("stat_ch1_zero", 64'(stat_accepted[31:16]), 64'h0);
`endif

    @(negedge clk);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/instruction_input_arbiter.md
# instruction_input_arbiter

Multi-channel successor to the single move/immediate instruction input port. It accepts move (source address) and immediate (data) words from CHANNELS independent producers over valid/ack handshakes and arbitrates them round-robin. Accepted words go into one shared FIFO of DEPTH entries, which presents a single tagged instruction stream to the instruction decoder. The block sits between the per-lane instruction fetch producers and the processing-element control unit.

## Interface
Parameters:
- ADDR_WIDTH, 8, width of a move source address
- DATA_WIDTH, 32, width of an immediate
- CHANNELS, 4, number of producer channels (≥2)
- DEPTH, 4, shared FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- in_move_from  in  CHANNELS*ADDR_WIDTH  per-channel move address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
- in_move_valid  in  CHANNELS  per-channel move request
- in_move_ack  out  CHANNELS  per-channel move accept
- in_immediate  in  CHANNELS*DATA_WIDTH  per-channel immediate, same packing
- in_immediate_valid  in  CHANNELS  per-channel immediate request
- in_immediate_ack  out  CHANNELS  per-channel immediate accept
- out_kind  out  1  0 = move, 1 = immediate
- out_channel  out  $clog2(CHANNELS)  source channel of head entry
- out_move_from  out  ADDR_WIDTH  head address (valid when out_kind=0)
- out_immediate  out  DATA_WIDTH  head immediate (valid when out_kind=1)
- out_valid  out  1  FIFO non-empty
- out_ack  in  1  consumer accepts head

## Operation
- Transfer rule on every channel: a word moves when valid && ack are both high in the same cycle. The producer holds valid and data stable until ack.
- Request of channel c: in_move_valid[c] | in_immediate_valid[c]. Within a channel, move has priority over immediate.
- Grant: at most one word per cycle. Search starts at round-robin pointer rr and picks the first requesting channel c in order rr, rr+1, … mod CHANNELS. No grant is made if the FIFO is full.
- The ack for the granted word is combinational from valid, rr and the full flag. It does not depend on out_ack, so there is no input-to-output combinational path.
- After a grant to channel c, rr ← (c+1) mod CHANNELS. Without a grant, rr holds.
- Push writes {kind, c, address or immediate} at wr_ptr. The unused payload field is written as zero.
- Pop occurs when out_valid && out_ack and advances rd_ptr.
- Pointers wrap modulo DEPTH. Occupancy counter ranges 0..DEPTH.
- Full blocks push even if a pop happens in the same cycle. Empty with a push: the entry appears next cycle.
- Simultaneous push and pop when not full and not empty: occupancy unchanged.
- out_ack while out_valid=0 is ignored.
- Reset (resetn=0 at a clock edge), including mid-transfer:
  - FIFO emptied, rr=0, storage cleared to zero.
  - All out_* = 0, all acks = 0.
  - Any in-flight unacked word is not accepted; the producer re-presents it after reset.

## Timing
- Input-to-output latency: 1 cycle. A word acked in cycle N is visible on out_* with out_valid=1 in cycle N+1 if the FIFO was empty.
- Throughput: 1 word per cycle sustained when out_ack stays high.
- out_* are driven from registers/storage at rd_ptr. They are stable while out_valid=1 and out_ack=0.
- Acks are combinational in the same cycle as valid.

## Configuration
- INSTR_ARB_STATS_EN defined:
  - Adds output stat_accepted (CHANNELS*16), one counter per channel.
  - A counter increments on each accepted move or immediate from its channel and saturates at 16'hFFFF.
  - Counters are cleared by reset.
- Undefined: the port and counters are absent. All other behaviour is identical.

## Test plan
- Reset then idle: all out_*=0, acks=0, rr=0. Hold resetn=0 for 3 cycles with all valids high → no acks.
- Single transfer: ch2 move_from=8'h5A, valid for one cycle with out_ack=0 → in_move_ack[2]=1 same cycle. Next cycle out_valid=1, out_kind=0, out_channel=2, out_move_from=8'h5A.
- Round-robin fairness: all 4 channels hold move_valid, out_ack=1 → grants in order 0,1,2,3,0,… one per cycle.
- Intra-channel priority: ch1 move 8'h11 and immediate 32'hDEADBEEF both valid → move acked first, immediate acked on a later grant. Output order is move then immediate.
- Full/backpressure: out_ack=0 with DEPTH=4 → exactly 4 acks, then all acks 0. Raise out_ack with valids held → acks resume at most one per cycle. The FIFO never pushes while full, even in the pop cycle.
- Stats (INSTR_ARB_STATS_EN): 70000 accepted words on ch0 → stat_accepted[15:0] = 16'hFFFF.
